// File: rtl/id_ex_stage_pkg.sv
// Shared constants and control bundle for the ID/EX stage.
// ALU function codes, bubble control word and the hard-wired zero register.
package id_ex_stage_pkg;

    localparam int DW_DEF   = 32;
    localparam int RW_DEF   = 5;
    localparam int REG_ZERO = 0;

    localparam logic [5:0] ALUFUN_ADD = 6'b000000;
    localparam logic [5:0] ALUFUN_SUB = 6'b000001;
    localparam logic [5:0] ALUFUN_AND = 6'b011000;
    localparam logic [5:0] ALUFUN_OR  = 6'b011110;
    localparam logic [5:0] ALUFUN_XOR = 6'b010110;
    localparam logic [5:0] ALUFUN_NOR = 6'b010001;
    localparam logic [5:0] ALUFUN_SLL = 6'b100000;
    localparam logic [5:0] ALUFUN_SRL = 6'b100001;
    localparam logic [5:0] ALUFUN_SRA = 6'b100011;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic [5:0] alu_fun;
        logic       sign;
        logic       src1;
        logic       src2;
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between decode, the forwarding sources and the EX-stage operand logic.
// master drives ID fields and forwarding inputs; slave is the ID/EX stage.
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          id_valid;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic          id_rt_used;
    logic [RW-1:0] id_rd;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          id_mem_write;
    logic          id_mem_to_reg;
    logic [5:0]    id_alu_fun;
    logic          id_sign;
    logic          id_alu_src1;
    logic          id_alu_src2;
    logic [4:0]    id_shamt;
    logic [DW-1:0] id_imm;
    logic [DW-1:0] id_pc_plus4;

    logic          mem_reg_write;
    logic [RW-1:0] mem_rd;
    logic [DW-1:0] mem_result;
    logic          wb_reg_write;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_result;

    logic          hold;
    logic          flush;

    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [5:0]    alu_fun;
    logic          alu_sign;
    logic [DW-1:0] ex_store_data;
    logic          ex_valid;
    logic [RW-1:0] ex_rd;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_mem_to_reg;
    logic [DW-1:0] ex_pc_plus4;
    logic          load_use_stall;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_data, id_rt_data,
        output id_rt_used, id_rd, id_reg_write, id_mem_read,
        output id_mem_write, id_mem_to_reg, id_alu_fun, id_sign,
        output id_alu_src1, id_alu_src2, id_shamt, id_imm,
        output id_pc_plus4,
        output mem_reg_write, mem_rd, mem_result,
        output wb_reg_write, wb_rd, wb_result,
        output hold, flush,
        input  alu_a, alu_b, alu_fun, alu_sign, ex_store_data,
        input  ex_valid, ex_rd, ex_reg_write, ex_mem_read,
        input  ex_mem_write, ex_mem_to_reg, ex_pc_plus4,
        input  load_use_stall
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_data, id_rt_data,
        input  id_rt_used, id_rd, id_reg_write, id_mem_read,
        input  id_mem_write, id_mem_to_reg, id_alu_fun, id_sign,
        input  id_alu_src1, id_alu_src2, id_shamt, id_imm,
        input  id_pc_plus4,
        input  mem_reg_write, mem_rd, mem_result,
        input  wb_reg_write, wb_rd, wb_result,
        input  hold, flush,
        output alu_a, alu_b, alu_fun, alu_sign, ex_store_data,
        output ex_valid, ex_rd, ex_reg_write, ex_mem_read,
        output ex_mem_write, ex_mem_to_reg, ex_pc_plus4,
        output load_use_stall
    );

endinterface

// File: rtl/id_ex_stage_operand_fwd.sv
// Resolves one EX operand from EX/MEM, MEM/WB or the latched register value.
// The younger producer (EX/MEM) wins; register zero is never forwarded.
module operand_fwd
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] idx_i,
    input  logic [DW-1:0] data_i,
    input  logic          mem_reg_write_i,
    input  logic [RW-1:0] mem_rd_i,
    input  logic [DW-1:0] mem_result_i,
    input  logic          wb_reg_write_i,
    input  logic [RW-1:0] wb_rd_i,
    input  logic [DW-1:0] wb_result_i,
    output logic [DW-1:0] data_o
);

    logic hit_mem;
    logic hit_wb;

    assign hit_mem = mem_reg_write_i
                   & (mem_rd_i != RW'(REG_ZERO))
                   & (mem_rd_i == idx_i);
    assign hit_wb  = wb_reg_write_i
                   & (wb_rd_i != RW'(REG_ZERO))
                   & (wb_rd_i == idx_i);

    always_comb begin
        data_o = data_i;
        if (hit_mem) begin
            data_o = mem_result_i;
        end else if (hit_wb) begin
            data_o = wb_result_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side forwarding, operand select
// and load-use hazard detection.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input logic         clk,
    input logic         reset,
    id_ex_stage_if.slave bus
);

    logic          valid_q, valid_d;
    logic [RW-1:0] rs_q, rs_d;
    logic [RW-1:0] rt_q, rt_d;
    logic [RW-1:0] rd_q, rd_d;
    logic [DW-1:0] rs_data_q, rs_data_d;
    logic [DW-1:0] rt_data_q, rt_data_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [DW-1:0] pc4_q, pc4_d;
    logic [4:0]    shamt_q, shamt_d;
    ex_ctrl_t      ctrl_q, ctrl_d;
    ex_ctrl_t      id_ctrl;

    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;
    logic          stall;
    logic          take_bubble;
    logic          take_id;

    operand_fwd #(.DW(DW), .RW(RW)) u_fwd_rs (
        .idx_i           (rs_q),
        .data_i          (rs_data_q),
        .mem_reg_write_i (bus.mem_reg_write),
        .mem_rd_i        (bus.mem_rd),
        .mem_result_i    (bus.mem_result),
        .wb_reg_write_i  (bus.wb_reg_write),
        .wb_rd_i         (bus.wb_rd),
        .wb_result_i     (bus.wb_result),
        .data_o          (fwd_rs)
    );

    operand_fwd #(.DW(DW), .RW(RW)) u_fwd_rt (
        .idx_i           (rt_q),
        .data_i          (rt_data_q),
        .mem_reg_write_i (bus.mem_reg_write),
        .mem_rd_i        (bus.mem_rd),
        .mem_result_i    (bus.mem_result),
        .wb_reg_write_i  (bus.wb_reg_write),
        .wb_rd_i         (bus.wb_rd),
        .wb_result_i     (bus.wb_result),
        .data_o          (fwd_rt)
    );

    assign stall = valid_q & ctrl_q.mem_read
                 & (rd_q != RW'(REG_ZERO))
                 & bus.id_valid
                 & ((rd_q == bus.id_rs)
                   | (bus.id_rt_used & (rd_q == bus.id_rt)))
                 & ~bus.hold & ~bus.flush;

    assign id_ctrl.reg_write  = bus.id_reg_write;
    assign id_ctrl.mem_read   = bus.id_mem_read;
    assign id_ctrl.mem_write  = bus.id_mem_write;
    assign id_ctrl.mem_to_reg = bus.id_mem_to_reg;
    assign id_ctrl.alu_fun    = bus.id_alu_fun;
    assign id_ctrl.sign       = bus.id_sign;
    assign id_ctrl.src1       = bus.id_alu_src1;
    assign id_ctrl.src2       = bus.id_alu_src2;

    // An empty ID slot enters EX as a bubble as well.
    assign take_bubble = bus.flush
                       | (~bus.hold & (stall | ~bus.id_valid));
    assign take_id     = ~bus.flush & ~bus.hold
                       & ~stall & bus.id_valid;

    always_comb begin
        valid_d   = valid_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        imm_d     = imm_q;
        pc4_d     = pc4_q;
        shamt_d   = shamt_q;
        ctrl_d    = ctrl_q;
        // Held operands track forwarding so a retiring producer is not lost.
        rs_data_d = fwd_rs;
        rt_data_d = fwd_rt;
        if (take_bubble) begin
            valid_d   = 1'b0;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
            imm_d     = '0;
            pc4_d     = '0;
            shamt_d   = '0;
            ctrl_d    = BUBBLE;
            rs_data_d = '0;
            rt_data_d = '0;
        end else if (take_id) begin
            valid_d   = 1'b1;
            rs_d      = bus.id_rs;
            rt_d      = bus.id_rt;
            rd_d      = bus.id_rd;
            imm_d     = bus.id_imm;
            pc4_d     = bus.id_pc_plus4;
            shamt_d   = bus.id_shamt;
            ctrl_d    = id_ctrl;
            rs_data_d = bus.id_rs_data;
            rt_data_d = bus.id_rt_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            pc4_q     <= '0;
            shamt_q   <= '0;
            ctrl_q    <= BUBBLE;
            rs_data_q <= '0;
            rt_data_q <= '0;
        end else begin
            valid_q   <= valid_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            imm_q     <= imm_d;
            pc4_q     <= pc4_d;
            shamt_q   <= shamt_d;
            ctrl_q    <= ctrl_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
        end
    end

    assign bus.alu_a = ctrl_q.src1
                     ? {{(DW-5){1'b0}}, shamt_q}
                     : fwd_rs;
    assign bus.alu_b = ctrl_q.src2 ? imm_q : fwd_rt;

    assign bus.alu_fun        = ctrl_q.alu_fun;
    assign bus.alu_sign       = ctrl_q.sign;
    assign bus.ex_store_data  = fwd_rt;
    assign bus.ex_valid       = valid_q;
    assign bus.ex_rd          = rd_q;
    assign bus.ex_reg_write   = ctrl_q.reg_write;
    assign bus.ex_mem_read    = ctrl_q.mem_read;
    assign bus.ex_mem_write   = ctrl_q.mem_write;
    assign bus.ex_mem_to_reg  = ctrl_q.mem_to_reg;
    assign bus.ex_pc_plus4    = pc4_q;
    assign bus.load_use_stall = stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for forwarding/operand
// select, plus hand sequences for load-use, hold, flush and reset.
module tb_id_ex_stage;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    id_ex_stage_if #(.DW(32), .RW(5)) bus ();

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [4:0]  rd;
        logic [5:0]  fun;
        logic        sgn;
        logic        s1;
        logic        s2;
        logic [4:0]  sh;
        logic [31:0] imm;
        logic        mw;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] es;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_valid      = 0;
        bus.id_rs         = 0;
        bus.id_rt         = 0;
        bus.id_rs_data    = 0;
        bus.id_rt_data    = 0;
        bus.id_rt_used    = 0;
        bus.id_rd         = 0;
        bus.id_reg_write  = 0;
        bus.id_mem_read   = 0;
        bus.id_mem_write  = 0;
        bus.id_mem_to_reg = 0;
        bus.id_alu_fun    = 0;
        bus.id_sign       = 0;
        bus.id_alu_src1   = 0;
        bus.id_alu_src2   = 0;
        bus.id_shamt      = 0;
        bus.id_imm        = 0;
        bus.id_pc_plus4   = 0;
        bus.mem_reg_write = 0;
        bus.mem_rd        = 0;
        bus.mem_result    = 0;
        bus.wb_reg_write  = 0;
        bus.wb_rd         = 0;
        bus.wb_result     = 0;
        bus.hold          = 0;
        bus.flush         = 0;
    endtask

    task automatic drive_lw8();
        clear_inputs();
        bus.id_valid      = 1;
        bus.id_rs         = 29;
        bus.id_rd         = 8;
        bus.id_reg_write  = 1;
        bus.id_mem_read   = 1;
        bus.id_mem_to_reg = 1;
        bus.id_alu_src2   = 1;
        bus.id_imm        = 32'h10;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;

        // reset state
        chk("rst ex_valid", 32'(bus.ex_valid), 0);
        chk("rst alu_fun", 32'(bus.alu_fun), 0);
        chk("rst alu_a", bus.alu_a, 0);
        chk("rst alu_b", bus.alu_b, 0);
        chk("rst store", bus.ex_store_data, 0);
        chk("rst ctrls", 32'({bus.ex_reg_write, bus.ex_mem_read,
            bus.ex_mem_write, bus.ex_mem_to_reg, bus.alu_sign}), 0);
        chk("rst stall", 32'(bus.load_use_stall), 0);

        vecs[0] = '{1, 2, 5, 7, 3, 6'b000000, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 5, 7, 7};
        vecs[1] = '{4, 5, 1, 2, 6, 6'b000000, 0, 0, 0, 0, 0,
                    1, 4, 32'hAA, 1, 4, 32'hBB, 32'hAA, 2, 2};
        vecs[2] = '{0, 0, 32'h11, 32'h22, 7, 6'b000000, 0, 0, 0, 0, 0,
                    1, 0, 32'h33, 1, 0, 32'h44, 32'h11, 32'h22, 32'h22};
        vecs[3] = '{6, 7, 3, 4, 8, 6'b000001, 1, 0, 0, 0, 0,
                    1, 9, 32'h99, 1, 7, 32'h77, 3, 32'h77, 32'h77};
        vecs[4] = '{8, 2, 9, 4, 9, 6'b011000, 0, 0, 0, 0, 0,
                    0, 8, 32'h66, 1, 8, 32'h55, 32'h55, 4, 4};
        vecs[5] = '{0, 9, 0, 32'h10, 10, 6'b100000, 0, 1, 0, 3, 0,
                    1, 9, 32'hF0, 0, 0, 0, 3, 32'hF0, 32'hF0};
        vecs[6] = '{10, 11, 32'h100, 9, 11, 6'b000000, 1, 0, 1, 0,
                    32'hFFFFFFFC, 0, 0, 0, 0, 0, 0,
                    32'h100, 32'hFFFFFFFC, 9};
        vecs[7] = '{13, 14, 1, 2, 12, 6'b011110, 0, 0, 0, 0, 0,
                    1, 14, 32'hCC, 1, 14, 32'hDD, 1, 32'hCC, 32'hCC};

        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            bus.id_valid      = 1;
            bus.id_reg_write  = 1;
            bus.id_rs         = vecs[i].rs;
            bus.id_rt         = vecs[i].rt;
            bus.id_rs_data    = vecs[i].rs_d;
            bus.id_rt_data    = vecs[i].rt_d;
            bus.id_rt_used    = 1;
            bus.id_rd         = vecs[i].rd;
            bus.id_alu_fun    = vecs[i].fun;
            bus.id_sign       = vecs[i].sgn;
            bus.id_alu_src1   = vecs[i].s1;
            bus.id_alu_src2   = vecs[i].s2;
            bus.id_shamt      = vecs[i].sh;
            bus.id_imm        = vecs[i].imm;
            bus.id_pc_plus4   = 32'h1000 + 32'(4 * i);
            bus.mem_reg_write = vecs[i].mw;
            bus.mem_rd        = vecs[i].mrd;
            bus.mem_result    = vecs[i].mres;
            bus.wb_reg_write  = vecs[i].ww;
            bus.wb_rd         = vecs[i].wrd;
            bus.wb_result     = vecs[i].wres;
            tick();
            chk($sformatf("v%0d alu_a", i), bus.alu_a, vecs[i].ea);
            chk($sformatf("v%0d alu_b", i), bus.alu_b, vecs[i].eb);
            chk($sformatf("v%0d store", i),
                bus.ex_store_data, vecs[i].es);
            chk($sformatf("v%0d fun", i),
                32'(bus.alu_fun), 32'(vecs[i].fun));
            chk($sformatf("v%0d sign", i),
                32'(bus.alu_sign), 32'(vecs[i].sgn));
            chk($sformatf("v%0d rd", i),
                32'(bus.ex_rd), 32'(vecs[i].rd));
            chk($sformatf("v%0d valid", i), 32'(bus.ex_valid), 1);
            chk($sformatf("v%0d regw", i),
                32'(bus.ex_reg_write), 1);
            chk($sformatf("v%0d pc4", i), bus.ex_pc_plus4,
                32'h1000 + 32'(4 * i));
        end

        // load-use on rt
        drive_lw8();
        tick();
        chk("lw ex_mem_read", 32'(bus.ex_mem_read), 1);
        clear_inputs();
        bus.id_valid     = 1;
        bus.id_rs        = 1;
        bus.id_rt        = 8;
        bus.id_rt_used   = 1;
        bus.id_rd        = 9;
        bus.id_reg_write = 1;
        #1;
        chk("lu rt stall", 32'(bus.load_use_stall), 1);
        tick();
        chk("lu bubble valid", 32'(bus.ex_valid), 0);
        chk("lu bubble mrd", 32'(bus.ex_mem_read), 0);
        chk("lu bubble rd", 32'(bus.ex_rd), 0);
        chk("lu bubble stall", 32'(bus.load_use_stall), 0);

        // rt not used and rs differs: no stall; hold masks stall
        drive_lw8();
        tick();
        clear_inputs();
        bus.id_valid   = 1;
        bus.id_rs      = 2;
        bus.id_rt      = 8;
        bus.id_rt_used = 0;
        bus.id_rd      = 9;
        #1;
        chk("lu unused rt", 32'(bus.load_use_stall), 0);
        bus.id_rt_used = 1;
        bus.hold       = 1;
        #1;
        chk("lu hold mask", 32'(bus.load_use_stall), 0);
        bus.hold  = 0;
        bus.flush = 1;
        #1;
        chk("lu flush mask", 32'(bus.load_use_stall), 0);
        bus.flush      = 0;
        bus.id_rt_used = 0;
        bus.id_rs      = 8;
        #1;
        chk("lu rs stall", 32'(bus.load_use_stall), 1);
        tick();
        chk("lu rs bubble", 32'(bus.ex_valid), 0);

        // hold with retiring WB producer
        clear_inputs();
        bus.id_valid     = 1;
        bus.id_rs        = 12;
        bus.id_rs_data   = 1;
        bus.id_rd        = 13;
        bus.id_reg_write = 1;
        bus.wb_reg_write = 1;
        bus.wb_rd        = 12;
        bus.wb_result    = 32'h1234;
        tick();
        chk("hold fwd", bus.alu_a, 32'h1234);
        bus.hold = 1;
        tick();
        bus.wb_reg_write = 0;
        bus.id_rs        = 3;
        bus.id_rs_data   = 32'hDEAD;
        bus.id_rd        = 20;
        #1;
        chk("hold keep a", bus.alu_a, 32'h1234);
        tick();
        chk("hold keep a2", bus.alu_a, 32'h1234);
        chk("hold keep rd", 32'(bus.ex_rd), 13);
        chk("hold keep valid", 32'(bus.ex_valid), 1);

        // flush wins over hold
        bus.flush = 1;
        tick();
        chk("flush valid", 32'(bus.ex_valid), 0);
        chk("flush fun", 32'(bus.alu_fun), 0);
        chk("flush regw", 32'(bus.ex_reg_write), 0);
        chk("flush a", bus.alu_a, 0);

        // reset mid-stream
        clear_inputs();
        bus.id_valid      = 1;
        bus.id_rs         = 5;
        bus.id_rs_data    = 32'h42;
        bus.id_rd         = 6;
        bus.id_reg_write  = 1;
        bus.id_mem_write  = 1;
        bus.id_alu_fun    = 6'b000001;
        bus.id_sign       = 1;
        tick();
        chk("pre-rst fun", 32'(bus.alu_fun), 1);
        reset = 1;
        tick();
        reset = 0;
        bus.id_valid = 0;
        chk("mid rst valid", 32'(bus.ex_valid), 0);
        chk("mid rst fun", 32'(bus.alu_fun), 0);
        chk("mid rst ctrls", 32'({bus.ex_reg_write, bus.ex_mem_read,
            bus.ex_mem_write, bus.ex_mem_to_reg, bus.alu_sign}), 0);
        chk("mid rst a", bus.alu_a, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
